instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter: CNT_W, 8, width of the word-count and index counters.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin a program load.
REQ-006 Port: word_count  input  CNT_W  number of 32-bit words to load; sampled on the accepted start.
REQ-007 Port: byte_in  input  8  program byte stream, most significant byte of each word first.
REQ-008 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-009 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: mem_we  output  1  single-cycle write strobe to instruction memory.
REQ-011 Port: mem_addr  output  32  word-aligned byte address of the write.
REQ-012 Port: mem_wdata  output  32  instruction word to write.
REQ-013 Port: core_hold  output  1  holds the processor's program counter and fetch stalled while high.
REQ-014 Port: busy  output  1  a load is in progress.
REQ-015 Port: done  output  1  last load finished; program released.
REQ-016 Port: checksum  output  32  XOR of all words written in the current or last load.

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, WRITE and DONE.
REQ-018 In IDLE, start=1 SHALL latch word_count, clear the index, byte counter and checksum, and move to COLLECT; if word_count=0, it SHALL move to DONE instead.
REQ-019 byte_ready SHALL be 1 only in COLLECT; a byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1.
REQ-020 Each accepted byte SHALL shift into a 32-bit assembly register from the LSB side, so the first byte ends in bits [31:24].
REQ-021 When the 4th byte of a word is accepted, the FSM SHALL move to WRITE on the next edge.
REQ-022 In WRITE, mem_we SHALL be 1 for exactly one cycle.
REQ-023 During that cycle, mem_wdata SHALL be the assembled word and mem_addr SHALL be BASE_ADDR + 4*index, computed modulo 2^32.
REQ-024 Latency: mem_we SHALL assert in the cycle immediately after the 4th byte is accepted; the minimum is 5 cycles per word.
REQ-025 On leaving WRITE, the index SHALL increment, the byte counter SHALL clear, and checksum SHALL become checksum XOR mem_wdata.
REQ-026 From WRITE, the FSM SHALL go to DONE if index+1 = latched count, otherwise to COLLECT.
REQ-027 mem_we SHALL be 0 in all states other than WRITE; mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-028 busy SHALL be 1 in COLLECT and WRITE; done and core_hold=0 SHALL hold only in DONE; core_hold SHALL be 1 in IDLE, COLLECT and WRITE.
REQ-029 In DONE, start=1 SHALL begin a new load exactly as from IDLE, and core_hold SHALL rise on the following edge.
REQ-030 start SHALL be ignored in COLLECT and WRITE, and the latched count SHALL be unaffected.
REQ-031 byte_valid while byte_ready=0 SHALL not consume or shift any data.
REQ-032 The count and index SHALL not wrap, since word_count ≤ 2^CNT_W-1.

Reset
REQ-033 While rst=1, the block SHALL immediately, without waiting for clk, enter IDLE and reset its outputs to byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, busy=0, done=0, checksum=0.
REQ-034 Reset mid-load SHALL discard any partial word, and no mem_we SHALL be issued for it; memory already written is not rolled back.

Verification
REQ-035 Scenario: start, word_count=2, bytes 20 08 00 05 8C 09 00 04 with continuous valid -> writes 32'h20080005 @0x0 then 32'h8C090004 @0x4; done=1, core_hold=0, checksum=32'hAC010001.
REQ-036 Scenario: start with word_count=0 -> DONE on the next edge, no mem_we, checksum=0.
REQ-037 Scenario: byte_valid toggled 1/0 every cycle, one word 32'hDEADBEEF -> a single write with correct data; no byte is duplicated or lost.
REQ-038 Scenario: start pulsed during COLLECT with word_count=5, after a load of 3 words started -> exactly 3 writes occur.
REQ-039 Scenario: rst asserted after 2 bytes of the second word -> outputs reset asynchronously, no second write, core_hold=1; a new start reloads from BASE_ADDR.
REQ-040 Scenario: BASE_ADDR=32'h0040_0000, word_count=3 -> addresses 0x00400000, 0x00400004, 0x00400008.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Loader-side bundle: byte-stream input, instruction-memory write port and load status.
// Both DUT sides and drivers share one definition so widths cannot drift apart.
interface instr_mem_loader_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] word_count;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             core_hold;
   logic             busy;
   logic             done;
   logic [31:0]      checksum;

   modport slave (
      input  start, word_count, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, checksum
   );

   modport master (
      output start, word_count, byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, checksum
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs an MSB-first byte stream into 32-bit words and writes them to instruction memory.
// One write strobe the cycle after a word's 4th byte (>=5 cycles/word); byte_ready drops while writing.
module instr_mem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   instr_mem_loader_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] idx_inc;
   logic [1:0]       byte_cnt;
   logic [31:0]      asm_word;
   logic [31:0]      wr_addr;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      checksum_q;
   logic             start_ok;

   assign idx_inc  = idx + CNT_W'(1);
   assign wr_addr  = BASE_ADDR + (32'(idx) << 2);
   assign start_ok = bus.start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      bus.byte_ready = 1'b0;
      bus.mem_we     = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      bus.core_hold  = 1'b1;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.word_count == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            bus.byte_ready = 1'b1;
            bus.busy       = 1'b1;
            if (bus.byte_valid && (byte_cnt == 2'd3)) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            bus.mem_we = 1'b1;
            bus.busy   = 1'b1;
            state_nxt  = (idx_inc == cnt) ? DONE : COLLECT;
         end
         DONE: begin
            bus.done      = 1'b1;
            bus.core_hold = 1'b0;
            if (bus.start) begin
               state_nxt = (bus.word_count == '0) ? DONE : COLLECT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The live word drives the write port only during WRITE; the registered copies hold it afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         byte_cnt   <= 2'd0;
         asm_word   <= 32'h0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         checksum_q <= 32'h0;
      end else begin
         if (start_ok) begin
            cnt        <= bus.word_count;
            idx        <= '0;
            byte_cnt   <= 2'd0;
            asm_word   <= 32'h0;
            checksum_q <= 32'h0;
         end
         if ((state == COLLECT) && bus.byte_valid) begin
            asm_word <= {asm_word[23:0], bus.byte_in};
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == WRITE) begin
            idx        <= idx_inc;
            byte_cnt   <= 2'd0;
            checksum_q <= checksum_q ^ asm_word;
            addr_q     <= wr_addr;
            wdata_q    <= asm_word;
         end
      end
   end

   assign bus.mem_addr  = (state == WRITE) ? wr_addr  : addr_q;
   assign bus.mem_wdata = (state == WRITE) ? asm_word : wdata_q;
   assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: two DUTs (different base addresses) share one stimulus stream;
// expected writes are queued as words are sent and popped by a negedge monitor.
module tb_instr_mem_loader;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0040_0000;
   localparam int          CNT_W = 8;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
   } wr_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] word_count = '0;
   logic [7:0]       byte_in = 8'h0;
   logic             byte_valid = 1'b0;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   wr_t         q0[$];
   wr_t         q1[$];
   logic [31:0] last_a0 = 32'h0;
   logic [31:0] last_d0 = 32'h0;
   logic [31:0] last_a1 = 32'h0;
   logic [31:0] last_d1 = 32'h0;
   logic [31:0] words[$];

   instr_mem_loader_if #(.CNT_W(CNT_W)) bus0 ();
   instr_mem_loader_if #(.CNT_W(CNT_W)) bus1 ();

   assign bus0.start      = start;
   assign bus0.word_count = word_count;
   assign bus0.byte_in    = byte_in;
   assign bus0.byte_valid = byte_valid;
   assign bus1.start      = start;
   assign bus1.word_count = word_count;
   assign bus1.byte_in    = byte_in;
   assign bus1.byte_valid = byte_valid;

   instr_mem_loader #(.BASE_ADDR(BASE0), .CNT_W(CNT_W)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   instr_mem_loader #(.BASE_ADDR(BASE1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int d, input logic we, input logic [31:0] addr, input logic [31:0] data);
      wr_t e;
      bit  has;
      has = 1'b0;
      if (we) begin
         if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); has = 1'b1; end
         if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); has = 1'b1; end
         if (!has) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write dut%0d addr=%h data=%h expected no write", d, addr, data);
         end else begin
            chk($sformatf("wr_addr dut%0d", d), addr, e.addr);
            chk($sformatf("wr_data dut%0d", d), data, e.data);
            chk($sformatf("wr_cycle dut%0d", d), cyc, e.due);
         end
         if (d == 0) begin last_a0 = addr; last_d0 = data; end
         else        begin last_a1 = addr; last_d1 = data; end
      end else begin
         chk($sformatf("hold_addr dut%0d", d), addr, (d == 0) ? last_a0 : last_a1);
         chk($sformatf("hold_data dut%0d", d), data, (d == 0) ? last_d0 : last_d1);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata);
         mon(1, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata);
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, " byte_ready"}, {31'h0, bus0.byte_ready | bus1.byte_ready}, 32'h0);
      chk({tag, " mem_we"},     {31'h0, bus0.mem_we | bus1.mem_we},         32'h0);
      chk({tag, " mem_addr0"},  bus0.mem_addr,  32'h0);
      chk({tag, " mem_addr1"},  bus1.mem_addr,  32'h0);
      chk({tag, " mem_wdata"},  bus0.mem_wdata | bus1.mem_wdata, 32'h0);
      chk({tag, " core_hold"},  {31'h0, bus0.core_hold & bus1.core_hold}, 32'h1);
      chk({tag, " busy"},       {31'h0, bus0.busy | bus1.busy},             32'h0);
      chk({tag, " done"},       {31'h0, bus0.done | bus1.done},             32'h0);
      chk({tag, " checksum"},   bus0.checksum | bus1.checksum,              32'h0);
   endtask

   // Reset lands between clock edges so the outputs must clear without an edge.
   task automatic do_async_reset();
      #3;
      rst = 1'b1;
      byte_valid = 1'b0;
      start = 1'b0;
      #1;
      check_reset_outputs("midload_rst");
      last_a0 = 32'h0; last_d0 = 32'h0; last_a1 = 32'h0; last_d1 = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic start_load(input int n);
      start = 1'b1;
      word_count = CNT_W'(n);
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         chk("zero_done",     {31'h0, bus0.done & bus1.done}, 32'h1);
         chk("zero_busy",     {31'h0, bus0.busy},             32'h0);
         chk("zero_checksum", bus0.checksum | bus1.checksum,  32'h0);
      end else begin
         chk("start_ready",    {31'h0, bus0.byte_ready}, 32'h1);
         chk("start_corehold", {31'h0, bus0.core_hold & bus1.core_hold}, 32'h1);
         chk("start_busy",     {31'h0, bus1.busy},       32'h1);
         chk("start_checksum", bus0.checksum | bus1.checksum, 32'h0);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit inj, input bit last, input int widx, input logic [31:0] w);
      int  t;
      wr_t e;
      t = 0;
      byte_valid = 1'b1;
      byte_in = b;
      while (!bus0.byte_ready && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 40) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout byte=%h waited=%0d cycles expected ready", b, t);
         byte_valid = 1'b0;
         return;
      end
      if (inj) begin
         start = 1'b1;
         word_count = CNT_W'(5);
      end
      @(posedge clk); #1;
      start = 1'b0;
      byte_valid = 1'b0;
      byte_in = 8'($urandom);
      if (last) begin
         e.data = w;
         e.due = cyc;
         e.addr = BASE0 + 32'(widx) * 4;
         q0.push_back(e);
         e.addr = BASE1 + 32'(widx) * 4;
         q1.push_back(e);
      end
   endtask

   task automatic gap(input int mode);
      if (mode == 1) begin
         @(posedge clk); #1;
      end else if (mode == 2) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic do_load(input int n, input int mode, input int inj_byte, input int rst_byte,
                          output logic [31:0] cks);
      logic [31:0] w;
      cks = 32'h0;
      start_load(n);
      for (int i = 0; i < n; i++) begin
         w = words[i];
         for (int b = 0; b < 4; b++) begin
            if (4 * i + b == rst_byte) begin
               do_async_reset();
               return;
            end
            send_byte(w[31 - 8 * b -: 8], (4 * i + b) == inj_byte, b == 3, i, w);
            if (b == 3) cks = cks ^ w;
            gap(mode);
         end
      end
   endtask

   task automatic wait_done(input string tag, input logic [31:0] cks);
      int t;
      t = 0;
      while (!(bus0.done && bus1.done) && t < 60) begin
         @(posedge clk); #1;
         t++;
      end
      chk({tag, " done"},      {31'h0, bus0.done & bus1.done}, 32'h1);
      chk({tag, " core_hold"}, {31'h0, bus0.core_hold | bus1.core_hold}, 32'h0);
      chk({tag, " busy"},      {31'h0, bus0.busy | bus1.busy}, 32'h0);
      chk({tag, " checksum0"}, bus0.checksum, cks);
      chk({tag, " checksum1"}, bus1.checksum, cks);
      chk({tag, " pending"},   32'(q0.size() + q1.size()), 32'h0);
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cks;
      int          n;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      words = '{32'h2008_0005, 32'h8C09_0004};
      do_load(2, 0, -1, -1, cks);
      wait_done("two_words", 32'hAC01_0001);

      start_load(0);
      repeat (3) begin @(posedge clk); #1; end
      chk("zero_stays_done", {31'h0, bus0.done}, 32'h1);

      words = '{32'hDEAD_BEEF};
      do_load(1, 1, -1, -1, cks);
      wait_done("toggle_valid", 32'hDEAD_BEEF);

      rand_words(3);
      do_load(3, 2, 1, -1, cks);
      wait_done("start_ignored", cks);

      rand_words(2);
      do_load(2, 0, -1, 6, cks);
      chk("after_rst pending", 32'(q0.size() + q1.size()), 32'h0);
      repeat (2) begin @(posedge clk); #1; end
      chk("after_rst core_hold", {31'h0, bus0.core_hold & bus1.core_hold}, 32'h1);
      rand_words(1);
      do_load(1, 0, -1, -1, cks);
      wait_done("reload", cks);

      rand_words(3);
      do_load(3, 0, -1, -1, cks);
      wait_done("three_words", cks);

      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 8);
         rand_words(n);
         do_load(n, $urandom_range(0, 2), -1, -1, cks);
         wait_done($sformatf("rand%0d", r), cks);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
